sd_init_sequencer: RTL and testbench

Controller that drives the SD card SPI-mode power-up and initialisation sequence: power-up wait, dummy clocks, CMD0, CMD8, the CMD55/ACMD41 polling loop, CMD58, then the switch from 400 kHz to 25 MHz. It does not serialise bits. It issues one command transaction at a time to the SPI command engine over a req/done handshake and interprets each response. It sits between the top level (start/status, UART debug reporting) and the bit-level SD SPI engine.

---
 rtl/sd_pkg.sv | 54 +++++
 rtl/sd_wait_timer.sv | 37 +++
 rtl/sd_init_sequencer.sv | 264 ++++++++++++++++++++++++++
 tb/tb_sd_init_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD card SPI-mode initialisation sequencer:
// command indices, FSM states, error codes, R1 bit names and fixed CRCs.
package sd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWR_WAIT,
        ST_DUMMY,
        ST_CMD0,
        ST_CMD8,
        ST_CMD55,
        ST_ACMD41,
        ST_POLL_GAP,
        ST_CMD58,
        ST_FAST,
        ST_READY,
        ST_ERROR
    } sd_state_e;

    localparam logic [5:0] CMD_GO_IDLE      = 6'd0;
    localparam logic [5:0] CMD_SEND_IF_COND = 6'd8;
    localparam logic [5:0] CMD_APP_CMD      = 6'd55;
    localparam logic [5:0] ACMD_SEND_OP     = 6'd41;
    localparam logic [5:0] CMD_READ_OCR     = 6'd58;

    localparam logic [2:0] ERR_NONE        = 3'd0;
    localparam logic [2:0] ERR_CMD0        = 3'd1;
    localparam logic [2:0] ERR_CMD8        = 3'd2;
    localparam logic [2:0] ERR_CMD55       = 3'd3;
    localparam logic [2:0] ERR_ACMD41_TMO  = 3'd4;
    localparam logic [2:0] ERR_CMD58       = 3'd5;
    localparam logic [2:0] ERR_ENG_TIMEOUT = 3'd6;

    localparam int R1_IDLE_BIT        = 0;
    localparam int R1_ILLEGAL_CMD_BIT = 2;

    // R1 patterns the sequencer recognises: "ready", "in idle", "idle + illegal command"
    localparam logic [7:0] R1_READY   = 8'h00;
    localparam logic [7:0] R1_IN_IDLE = 8'(1 << R1_IDLE_BIT);
    localparam logic [7:0] R1_ILLEGAL = 8'((1 << R1_IDLE_BIT) | (1 << R1_ILLEGAL_CMD_BIT));

    localparam logic [6:0] CRC_CMD0  = 7'h4A;
    localparam logic [6:0] CRC_CMD8  = 7'h43;
    localparam logic [6:0] CRC_OTHER = 7'h7F;

    localparam logic [31:0] ARG_CMD8       = 32'h0000_01AA;
    localparam logic [31:0] ARG_ACMD41_HCS = 32'h4000_0000;

    // States in which a transaction is requested from the SPI engine
    function automatic logic is_eng_state(input sd_state_e s);
        return (s inside {ST_DUMMY, ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41, ST_CMD58});
    endfunction

endpackage

// File: rtl/sd_wait_timer.sv
// Loadable down-counter with a done flag; shared by the power-up wait
// and the gap between ACMD41 polling iterations.
module sd_wait_timer #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Load takes priority; otherwise count down and hold at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0) && !load;

endmodule

// File: rtl/sd_init_sequencer.sv
// SD card SPI-mode power-up/initialisation controller. Issues one command
// at a time to the bit-level engine and interprets the responses.
module sd_init_sequencer
    import sd_pkg::*;
#(
    parameter int CLK_HZ          = 100000000,
    parameter int PWR_WAIT_CYCLES = CLK_HZ / 1000,
    parameter int CMD0_RETRIES    = 10,
    parameter int ACMD41_RETRIES  = 1000,
    parameter int POLL_GAP_CYCLES = 10000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        init_done,
    output logic        init_error,
    output logic [2:0]  err_code,
    output logic        card_v2,
    output logic        card_hc,
    output logic        clk_fast,
    output logic        cs_n,
    output logic        eng_req,
    output logic        eng_op,
    output logic [5:0]  eng_cmd,
    output logic [31:0] eng_arg,
    output logic [6:0]  eng_crc,
    output logic        eng_resp_len,
    input  logic        eng_done,
    input  logic        eng_timeout,
    input  logic [39:0] eng_resp
);

    localparam int TIMER_MAX = (PWR_WAIT_CYCLES > POLL_GAP_CYCLES) ? PWR_WAIT_CYCLES : POLL_GAP_CYCLES;
    localparam int TIMER_W   = (TIMER_MAX < 1) ? 1 : $clog2(TIMER_MAX + 1);
    localparam int C0_W      = $clog2(CMD0_RETRIES + 2);
    localparam int A41_W     = $clog2(ACMD41_RETRIES + 2);

    sd_state_e          state_q, state_d;
    logic [2:0]         err_q, err_d;
    logic               v2_q, v2_d, hc_q, hc_d;
    logic [C0_W-1:0]    c0_cnt_q, c0_cnt_d;
    logic [A41_W-1:0]   a41_cnt_q, a41_cnt_d;
    logic               busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic               cs_n_q, cs_n_d, fast_q, fast_d;
    logic               req_q, req_d, op_q, op_d, len_q, len_d;
    logic [5:0]         cmd_q, cmd_d;
    logic [31:0]        arg_q, arg_d;
    logic [6:0]         crc_q, crc_d;
    logic               timer_load, timer_done;
    logic [TIMER_W-1:0] timer_val;
    logic               resp_ok;
    logic [7:0]         r1;
    logic               unused_resp;

    assign resp_ok     = req_q && eng_done;
    assign r1          = eng_resp[39:32];
    assign unused_resp = ^{eng_resp[31], eng_resp[29:12]};

    sd_wait_timer #(.WIDTH(TIMER_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    // Next-state logic: sequencing, retry counting and response decoding
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        v2_d       = v2_q;
        hc_d       = hc_q;
        c0_cnt_d   = c0_cnt_q;
        a41_cnt_d  = a41_cnt_q;
        timer_load = 1'b0;
        timer_val  = '0;
        case (state_q)
            ST_IDLE, ST_READY, ST_ERROR: begin
                if (start) begin
                    state_d    = ST_PWR_WAIT;
                    err_d      = ERR_NONE;
                    v2_d       = 1'b0;
                    hc_d       = 1'b0;
                    c0_cnt_d   = '0;
                    a41_cnt_d  = '0;
                    timer_load = 1'b1;
                    timer_val  = TIMER_W'(PWR_WAIT_CYCLES);
                end
            end
            ST_PWR_WAIT: if (timer_done) state_d = ST_DUMMY;
            ST_DUMMY:    if (resp_ok) state_d = ST_CMD0;
            ST_CMD0: begin
                if (resp_ok) begin
                    if (!eng_timeout && r1 == R1_IN_IDLE) begin
                        state_d = ST_CMD8;
                    end else if (c0_cnt_q >= C0_W'(CMD0_RETRIES - 1)) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_CMD0;
                    end else if (c0_cnt_q != '1) begin
                        c0_cnt_d = c0_cnt_q + 1'b1;
                    end
                end
            end
            ST_CMD8: begin
                if (resp_ok) begin
                    if (eng_timeout) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_ENG_TIMEOUT;
                    end else if (r1 == R1_IN_IDLE && eng_resp[11:0] == ARG_CMD8[11:0]) begin
                        v2_d    = 1'b1;
                        state_d = ST_CMD55;
                    end else if (r1 == R1_ILLEGAL) begin
                        v2_d    = 1'b0;
                        state_d = ST_CMD55;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = ERR_CMD8;
                    end
                end
            end
            ST_CMD55: begin
                if (resp_ok) begin
                    if (eng_timeout) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_ENG_TIMEOUT;
                    end else if (r1 == R1_READY || r1 == R1_IN_IDLE) begin
                        state_d = ST_ACMD41;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = ERR_CMD55;
                    end
                end
            end
            ST_ACMD41: begin
                if (resp_ok) begin
                    if (eng_timeout) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_ENG_TIMEOUT;
                    end else if (r1 == R1_READY) begin
                        state_d = v2_q ? ST_CMD58 : ST_FAST;
                    end else if (r1 == R1_IN_IDLE) begin
                        if (a41_cnt_q >= A41_W'(ACMD41_RETRIES - 1)) begin
                            state_d = ST_ERROR;
                            err_d   = ERR_ACMD41_TMO;
                        end else begin
                            state_d    = ST_POLL_GAP;
                            timer_load = 1'b1;
                            timer_val  = TIMER_W'(POLL_GAP_CYCLES);
                            if (a41_cnt_q != '1) a41_cnt_d = a41_cnt_q + 1'b1;
                        end
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = ERR_CMD55;
                    end
                end
            end
            ST_POLL_GAP: if (timer_done) state_d = ST_CMD55;
            ST_CMD58: begin
                if (resp_ok) begin
                    if (eng_timeout) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_ENG_TIMEOUT;
                    end else if (r1 == R1_READY) begin
                        hc_d    = eng_resp[30];
                        state_d = ST_FAST;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = ERR_CMD58;
                    end
                end
            end
            ST_FAST: state_d = ST_READY;
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs: status follows the next state, engine fields follow the current state
    always_comb begin
        busy_d  = !(state_d inside {ST_IDLE, ST_READY, ST_ERROR});
        done_d  = (state_d == ST_READY);
        error_d = (state_d == ST_ERROR);
        cs_n_d  = (state_d inside {ST_IDLE, ST_PWR_WAIT, ST_DUMMY, ST_ERROR});
        fast_d  = (state_d inside {ST_FAST, ST_READY});
        req_d   = is_eng_state(state_q) && !resp_ok;
        op_d    = (state_q == ST_DUMMY);
        len_d   = (state_q inside {ST_CMD8, ST_CMD58});
        cmd_d   = CMD_GO_IDLE;
        arg_d   = '0;
        crc_d   = CRC_OTHER;
        case (state_q)
            ST_CMD0:   crc_d = CRC_CMD0;
            ST_CMD8: begin
                cmd_d = CMD_SEND_IF_COND;
                arg_d = ARG_CMD8;
                crc_d = CRC_CMD8;
            end
            ST_CMD55:  cmd_d = CMD_APP_CMD;
            ST_ACMD41: begin
                cmd_d = ACMD_SEND_OP;
                arg_d = v2_q ? ARG_ACMD41_HCS : '0;
            end
            ST_CMD58:  cmd_d = CMD_READ_OCR;
            default:   cmd_d = CMD_GO_IDLE;
        endcase
    end

    // State, counters and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            err_q     <= ERR_NONE;
            v2_q      <= 1'b0;
            hc_q      <= 1'b0;
            c0_cnt_q  <= '0;
            a41_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            cs_n_q    <= 1'b1;
            fast_q    <= 1'b0;
            req_q     <= 1'b0;
            op_q      <= 1'b0;
            len_q     <= 1'b0;
            cmd_q     <= '0;
            arg_q     <= '0;
            crc_q     <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            v2_q      <= v2_d;
            hc_q      <= hc_d;
            c0_cnt_q  <= c0_cnt_d;
            a41_cnt_q <= a41_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            cs_n_q    <= cs_n_d;
            fast_q    <= fast_d;
            req_q     <= req_d;
            op_q      <= op_d;
            len_q     <= len_d;
            cmd_q     <= cmd_d;
            arg_q     <= arg_d;
            crc_q     <= crc_d;
        end
    end

    assign busy         = busy_q;
    assign init_done    = done_q;
    assign init_error   = error_q;
    assign err_code     = err_q;
    assign card_v2      = v2_q;
    assign card_hc      = hc_q;
    assign clk_fast     = fast_q;
    assign cs_n         = cs_n_q;
    assign eng_req      = req_q;
    assign eng_op       = op_q;
    assign eng_cmd      = cmd_q;
    assign eng_arg      = arg_q;
    assign eng_crc      = crc_q;
    assign eng_resp_len = len_q;

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Directed bench for sd_init_sequencer: a behavioural engine answers each
// request, and expected request fields are queued before each transaction.
module tb_sd_init_sequencer;

    localparam int PWR       = 20;
    localparam int POLL      = 15;
    localparam int C0_RET    = 10;
    localparam int A41_RET   = 5;
    localparam int REQ_LIMIT = 200;

    typedef struct packed {
        logic        op;
        logic [5:0]  cmd;
        logic [31:0] arg;
        logic        len;
        logic        crc_chk;
        logic [6:0]  crc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, init_done, init_error, card_v2, card_hc, clk_fast, cs_n;
    logic [2:0]  err_code;
    logic        eng_req, eng_op, eng_resp_len;
    logic [5:0]  eng_cmd;
    logic [31:0] eng_arg;
    logic [6:0]  eng_crc;
    logic        eng_done = 1'b0;
    logic        eng_timeout = 1'b0;
    logic [39:0] eng_resp = '1;

    exp_t expq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   waited;

    sd_init_sequencer #(
        .PWR_WAIT_CYCLES (PWR),
        .CMD0_RETRIES    (C0_RET),
        .ACMD41_RETRIES  (A41_RET),
        .POLL_GAP_CYCLES (POLL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .init_done    (init_done),
        .init_error   (init_error),
        .err_code     (err_code),
        .card_v2      (card_v2),
        .card_hc      (card_hc),
        .clk_fast     (clk_fast),
        .cs_n         (cs_n),
        .eng_req      (eng_req),
        .eng_op       (eng_op),
        .eng_cmd      (eng_cmd),
        .eng_arg      (eng_arg),
        .eng_crc      (eng_crc),
        .eng_resp_len (eng_resp_len),
        .eng_done     (eng_done),
        .eng_timeout  (eng_timeout),
        .eng_resp     (eng_resp)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [39:0] observed, input logic [39:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic expectQuiet(input int n, input string tag);
        logic seen_req;
        seen_req = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            if (eng_req !== 1'b0) seen_req = 1'b1;
        end
        checkOutput(tag, seen_req, 1'b0);
    endtask

    // Queue the expected request, wait for it, compare fields, then answer it
    task automatic applyStimulus(input logic op, input logic [5:0] cmd, input logic [31:0] arg,
                                 input logic len, input logic crc_chk, input logic [6:0] crc,
                                 input logic [7:0] r1, input logic [31:0] tail, input logic tmo,
                                 input logic respond, output int wait_cycles);
        exp_t e;
        logic seen;
        e.op = op; e.cmd = cmd; e.arg = arg; e.len = len; e.crc_chk = crc_chk; e.crc = crc;
        expq.push_back(e);
        wait_cycles = 0;
        seen = 1'b0;
        while (!seen && wait_cycles < REQ_LIMIT) begin
            @(posedge clk); #1;
            wait_cycles++;
            if (eng_req === 1'b1) seen = 1'b1;
        end
        e = expq.pop_front();
        if (!seen) begin
            checkOutput("req_wait_expired", 1'b0, 1'b1);
            return;
        end
        checkOutput("eng_op", eng_op, e.op);
        checkOutput("eng_resp_len", eng_resp_len, e.len);
        if (!e.op) begin
            checkOutput("eng_cmd", eng_cmd, e.cmd);
            checkOutput("eng_arg", eng_arg, e.arg);
            checkOutput("cs_n_in_cmd", cs_n, 1'b0);
        end
        if (e.crc_chk) checkOutput("eng_crc", eng_crc, e.crc);
        if (respond) begin
            repeat (2) @(posedge clk);
            #1;
            checkOutput("req_held", {eng_req, eng_cmd, eng_arg}, {1'b1, e.op ? eng_cmd : e.cmd, e.op ? eng_arg : e.arg});
            eng_resp    = {r1, tail};
            eng_timeout = tmo;
            eng_done    = 1'b1;
            @(posedge clk); #1;
            eng_done    = 1'b0;
            eng_timeout = 1'b0;
            eng_resp    = '1;
            checkOutput("req_dropped", eng_req, 1'b0);
        end
    endtask

    task automatic dummyPhase();
        applyStimulus(1'b1, 6'd0, 32'd0, 1'b0, 1'b0, 7'd0, 8'hFF, 32'hFFFF_FFFF, 1'b0, 1'b1, waited);
        checkOutput("pwr_wait_len", (waited >= PWR), 1'b1);
    endtask

    task automatic cmd(input logic [5:0] idx, input logic [31:0] arg, input logic len,
                       input logic crc_chk, input logic [6:0] crc,
                       input logic [7:0] r1, input logic [31:0] tail, input logic tmo);
        applyStimulus(1'b0, idx, arg, len, crc_chk, crc, r1, tail, tmo, 1'b1, waited);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs", {busy, init_done, init_error, err_code, card_v2, card_hc, clk_fast, cs_n, eng_req},
                    {1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        rst_n = 1'b1;
        expectQuiet(3, "idle_no_req");

        // Ideal v2 high-capacity card
        $display("[TB] v2 card");
        pulseStart();
        checkOutput("busy_after_start", {busy, cs_n, clk_fast}, {1'b1, 1'b1, 1'b0});
        dummyPhase();
        cmd(6'd0, 32'd0, 1'b0, 1'b1, 7'h4A, 8'h01, 32'hFFFF_FFFF, 1'b0);
        cmd(6'd8, 32'h1AA, 1'b1, 1'b1, 7'h43, 8'h01, 32'h0000_01AA, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cmd(6'd55, 32'd0, 1'b0, 1'b1, 7'h7F, 8'h01, 32'hFFFF_FFFF, 1'b0);
            if (i > 0) checkOutput("poll_gap_len", (waited >= POLL), 1'b1);
            cmd(6'd41, 32'h4000_0000, 1'b0, 1'b0, 7'd0, (i == 2) ? 8'h00 : 8'h01, 32'hFFFF_FFFF, 1'b0);
        end
        cmd(6'd58, 32'd0, 1'b1, 1'b0, 7'd0, 8'h00, 32'hC0FF_8000, 1'b0);
        expectQuiet(4, "v2_no_extra_req");
        checkOutput("v2_ready", {init_done, init_error, busy, card_v2, card_hc, clk_fast, cs_n, err_code},
                    {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0});

        // v1 card: CMD8 illegal, ACMD41 without HCS, no CMD58
        $display("[TB] v1 card");
        pulseStart();
        checkOutput("restart_clears", {card_v2, card_hc, clk_fast, cs_n}, {1'b0, 1'b0, 1'b0, 1'b1});
        dummyPhase();
        cmd(6'd0, 32'd0, 1'b0, 1'b1, 7'h4A, 8'h01, 32'hFFFF_FFFF, 1'b0);
        cmd(6'd8, 32'h1AA, 1'b1, 1'b1, 7'h43, 8'h05, 32'hFFFF_FFFF, 1'b0);
        cmd(6'd55, 32'd0, 1'b0, 1'b1, 7'h7F, 8'h01, 32'hFFFF_FFFF, 1'b0);
        cmd(6'd41, 32'd0, 1'b0, 1'b0, 7'd0, 8'h00, 32'hFFFF_FFFF, 1'b0);
        expectQuiet(10, "v1_no_cmd58");
        checkOutput("v1_ready", {init_done, card_v2, card_hc, clk_fast, err_code}, {1'b1, 1'b0, 1'b0, 1'b1, 3'd0});

        // CMD0 never answers in idle: exactly C0_RET attempts
        $display("[TB] CMD0 retries");
        pulseStart();
        dummyPhase();
        for (int i = 0; i < C0_RET; i++) cmd(6'd0, 32'd0, 1'b0, 1'b1, 7'h4A, 8'hFF, 32'hFFFF_FFFF, 1'b0);
        expectQuiet(10, "cmd0_no_extra_req");
        checkOutput("cmd0_error", {init_error, init_done, busy, err_code, cs_n, clk_fast},
                    {1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0});

        // ACMD41 stays in idle: give up after A41_RET iterations
        $display("[TB] ACMD41 timeout");
        pulseStart();
        dummyPhase();
        cmd(6'd0, 32'd0, 1'b0, 1'b1, 7'h4A, 8'h01, 32'hFFFF_FFFF, 1'b0);
        cmd(6'd8, 32'h1AA, 1'b1, 1'b1, 7'h43, 8'h01, 32'h0000_01AA, 1'b0);
        for (int i = 0; i < A41_RET; i++) begin
            cmd(6'd55, 32'd0, 1'b0, 1'b1, 7'h7F, 8'h01, 32'hFFFF_FFFF, 1'b0);
            if (i > 0) checkOutput("acmd41_gap_len", (waited >= POLL), 1'b1);
            cmd(6'd41, 32'h4000_0000, 1'b0, 1'b0, 7'd0, 8'h01, 32'hFFFF_FFFF, 1'b0);
        end
        expectQuiet(POLL + 10, "acmd41_no_extra_req");
        checkOutput("acmd41_error", {init_error, err_code, cs_n}, {1'b1, 3'd4, 1'b1});

        // Engine timeout on CMD58, then a clean restart
        $display("[TB] CMD58 engine timeout");
        pulseStart();
        dummyPhase();
        cmd(6'd0, 32'd0, 1'b0, 1'b1, 7'h4A, 8'h01, 32'hFFFF_FFFF, 1'b0);
        cmd(6'd8, 32'h1AA, 1'b1, 1'b1, 7'h43, 8'h01, 32'h0000_01AA, 1'b0);
        cmd(6'd55, 32'd0, 1'b0, 1'b1, 7'h7F, 8'h00, 32'hFFFF_FFFF, 1'b0);
        cmd(6'd41, 32'h4000_0000, 1'b0, 1'b0, 7'd0, 8'h00, 32'hFFFF_FFFF, 1'b0);
        cmd(6'd58, 32'd0, 1'b1, 1'b0, 7'd0, 8'hFF, 32'hFFFF_FFFF, 1'b1);
        expectQuiet(5, "tmo_no_extra_req");
        checkOutput("eng_timeout_error", {init_error, err_code, busy}, {1'b1, 3'd6, 1'b0});
        pulseStart();
        checkOutput("restart_err_clear", {init_error, err_code, busy}, {1'b0, 3'd0, 1'b1});
        dummyPhase();
        cmd(6'd0, 32'd0, 1'b0, 1'b1, 7'h4A, 8'h01, 32'hFFFF_FFFF, 1'b0);
        cmd(6'd8, 32'h1AA, 1'b1, 1'b1, 7'h43, 8'h01, 32'h0000_01AA, 1'b0);
        cmd(6'd55, 32'd0, 1'b0, 1'b1, 7'h7F, 8'h01, 32'hFFFF_FFFF, 1'b0);
        cmd(6'd41, 32'h4000_0000, 1'b0, 1'b0, 7'd0, 8'h00, 32'hFFFF_FFFF, 1'b0);
        cmd(6'd58, 32'd0, 1'b1, 1'b0, 7'd0, 8'h00, 32'h80FF_8000, 1'b0);
        expectQuiet(4, "rerun_no_extra_req");
        checkOutput("rerun_ready", {init_done, card_v2, card_hc, clk_fast}, {1'b1, 1'b1, 1'b0, 1'b1});

        // Asynchronous reset while ACMD41 is outstanding
        $display("[TB] reset mid-transaction");
        pulseStart();
        dummyPhase();
        cmd(6'd0, 32'd0, 1'b0, 1'b1, 7'h4A, 8'h01, 32'hFFFF_FFFF, 1'b0);
        cmd(6'd8, 32'h1AA, 1'b1, 1'b1, 7'h43, 8'h01, 32'h0000_01AA, 1'b0);
        cmd(6'd55, 32'd0, 1'b0, 1'b1, 7'h7F, 8'h01, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(1'b0, 6'd41, 32'h4000_0000, 1'b0, 1'b0, 7'd0, 8'h00, 32'd0, 1'b0, 1'b0, waited);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs", {busy, init_done, init_error, err_code, card_v2, card_hc, clk_fast, cs_n, eng_req},
                    {1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        expectQuiet(3, "post_reset_idle");
        pulseStart();
        checkOutput("post_reset_start", {busy, cs_n}, {1'b1, 1'b1});
        dummyPhase();
        checkOutput("queue_drained", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
